// File: rtl/mem_arb_pkg.sv
`default_nettype none
// =====================================================================
// mem_arb_pkg : shared state, size and owner types for mem_port_arbiter
// Rev 1.0
// =====================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2,
        GAP  = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        SZ_WORD = 2'b00,
        SZ_HALF = 2'b01,
        SZ_BYTE = 2'b10
    } mem_size_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// =====================================================================
// mem_port_arbiter : I/D two-port arbiter onto the unified memory block
// Optional BUSY watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
// Rev 1.0
// =====================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int D_BURST_MAX = 4
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 64
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_rw,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [1:0]  d_size,
    input  logic        d_unsigned,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_valid,
    output logic        mem_rw,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_size,
    output logic        mem_unsigned,
    input  logic        mem_ready,
    input  logic        mem_oor,
    input  logic [31:0] mem_rdata
);

    localparam int c_BURST_W = (D_BURST_MAX < 1) ? 1 : $clog2(D_BURST_MAX + 1);
    localparam logic [c_BURST_W-1:0] c_BURST_MAX = c_BURST_W'(D_BURST_MAX);

    arb_state_t             r_state;
    arb_state_t             w_state_nxt;
    arb_owner_t             r_owner;
    logic [c_BURST_W-1:0]   r_burst;
    logic                   w_grant;
    logic                   w_pick_d;
    logic                   w_finish;
    logic                   w_fail;
    logic                   w_tmo;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int c_TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_TMO_W-1:0] r_tmo;

    always_ff @(posedge clk) begin
        if (rst || (r_state != BUSY)) begin
            r_tmo <= '0;
        end else begin
            r_tmo <= r_tmo + 1'b1;
        end
    end

    // Fires in the last permitted BUSY cycle so the response follows immediately.
    assign w_tmo = (r_state == BUSY) && (r_tmo == c_TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_tmo = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_pick_d    = 1'b0;
        w_finish    = 1'b0;
        w_fail      = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_req || d_req) begin
                    w_grant     = 1'b1;
                    // D has priority until it has starved a pending fetch D_BURST_MAX times.
                    w_pick_d    = d_req && !(i_req && (r_burst == c_BURST_MAX));
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (mem_oor) begin
                    w_finish    = 1'b1;
                    w_fail      = 1'b1;
                    w_state_nxt = RESP;
                end else if (mem_ready) begin
                    w_finish    = 1'b1;
                    w_state_nxt = RESP;
                end else if (w_tmo) begin
                    w_finish    = 1'b1;
                    w_fail      = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP:    w_state_nxt = GAP;
            GAP:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner      <= OWN_I;
            r_burst      <= '0;
            mem_valid    <= 1'b0;
            mem_rw       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_size     <= '0;
            mem_unsigned <= 1'b0;
            i_ack        <= 1'b0;
            i_rdata      <= '0;
            i_err        <= 1'b0;
            d_ack        <= 1'b0;
            d_rdata      <= '0;
            d_err        <= 1'b0;
        end else begin
            i_ack <= 1'b0;
            i_err <= 1'b0;
            d_ack <= 1'b0;
            d_err <= 1'b0;

            if (w_grant) begin
                mem_valid <= 1'b1;
                if (w_pick_d && i_req) begin
                    r_burst <= r_burst + 1'b1;
                end else begin
                    r_burst <= '0;
                end
                if (w_pick_d) begin
                    r_owner      <= OWN_D;
                    mem_rw       <= d_rw;
                    mem_addr     <= d_addr;
                    mem_wdata    <= d_wdata;
                    mem_size     <= d_size;
                    mem_unsigned <= d_unsigned;
                end else begin
                    r_owner      <= OWN_I;
                    mem_rw       <= 1'b0;
                    mem_addr     <= i_addr;
                    mem_wdata    <= '0;
                    mem_size     <= SZ_WORD;
                    mem_unsigned <= 1'b0;
                end
            end

            if (w_finish) begin
                mem_valid <= 1'b0;
                if (r_owner == OWN_I) begin
                    i_ack   <= 1'b1;
                    i_err   <= w_fail;
                    i_rdata <= w_fail ? 32'h0 : mem_rdata;
                end else begin
                    d_ack   <= 1'b1;
                    d_err   <= w_fail;
                    d_rdata <= w_fail ? 32'h0 : mem_rdata;
                end
            end
        end
    end

endmodule
`default_nettype wire
